// File: rtl/mmio_pkg.sv
// ---------------------------------------------------------------------------
// mmio_pkg
// Shared definitions for the MMIO interconnect:
//   - state_t       : transaction FSM encoding
//   - STAT_*        : bit positions inside the bus status register
//   - TIMEOUT_DATA  : read data returned when a slot never answers
//   - slot_index()  : peripheral slot number for a given word address
// ---------------------------------------------------------------------------
package mmio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_RAMWAIT = 3'd2,
        ST_WAIT    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int STAT_ERR_BIT     = 0;
    localparam int STAT_TIMEOUT_BIT = 1;
    localparam int STAT_SLOT_LSB    = 4;
    localparam int STAT_SLOT_MSB    = 7;

    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

    // Slot number of an address inside the peripheral window. Only the low
    // four bits are kept, which covers the full 1..16 slot range.
    function automatic logic [3:0] slot_index(input logic [15:0] addr,
                                              input logic [15:0] base,
                                              input int          slot_aw);
        logic [15:0] offset;
        offset = (addr - base) >> slot_aw;
        return offset[3:0];
    endfunction

endpackage

// File: rtl/mmio_decode.sv
// ---------------------------------------------------------------------------
// mmio_decode
// Combinational address decoder for the MMIO interconnect. Exactly one of
// the outputs is active for any address.
//   addr          : CPU word address
//   is_ram        : address below 2^RAM_AW
//   is_slot       : one-hot peripheral slot hit
//   is_status     : address equals STATUS_ADDR
//   is_fault_addr : fault-address register (STATUS_ADDR-1), only when the
//                   MMIO_FAULT_ADDR_EN macro is defined; otherwise tied low
//   is_unmapped   : none of the above
// ---------------------------------------------------------------------------
module mmio_decode
    import mmio_pkg::*;
#(
    parameter int          RAM_AW      = 14,
    parameter logic [15:0] PERIPH_BASE = 16'h4000,
    parameter int          N_SLOTS     = 4,
    parameter int          SLOT_AW     = 2,
    parameter logic [15:0] STATUS_ADDR = 16'h7FFF
) (
    input  logic [15:0]        addr,
    output logic               is_ram,
    output logic [N_SLOTS-1:0] is_slot,
    output logic               is_status,
    output logic               is_fault_addr,
    output logic               is_unmapped
);

    localparam int SLOT_SPAN = 1 << SLOT_AW;

    // Compare in 32 bits so the top of the last slot window may reach 2^16.
    logic [31:0]        addr_ext;
    logic [N_SLOTS-1:0] slot_hit;

    assign addr_ext = {16'd0, addr};

    generate
        for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
            localparam int LO = int'(PERIPH_BASE) + gi * SLOT_SPAN;
            localparam int HI = LO + SLOT_SPAN;
            assign slot_hit[gi] = (addr_ext >= 32'(LO)) && (addr_ext < 32'(HI));
        end
    endgenerate

    assign is_ram    = addr_ext < 32'(1 << RAM_AW);
    assign is_status = !is_ram && (addr == STATUS_ADDR);

`ifdef MMIO_FAULT_ADDR_EN
    assign is_fault_addr = !is_ram && !is_status && (addr == STATUS_ADDR - 16'd1);
`else
    assign is_fault_addr = 1'b0;
`endif

    // RAM and the internal registers take precedence over a slot window that
    // has been placed on top of them.
    assign is_slot     = (is_ram || is_status || is_fault_addr) ? '0 : slot_hit;
    assign is_unmapped = !(is_ram || is_status || is_fault_addr || (|slot_hit));

endmodule

// File: rtl/mmio_interconnect.sv
// ---------------------------------------------------------------------------
// mmio_interconnect
// Memory-mapped bus fabric between the Hack CPU data port, a synchronous RAM
// and N_SLOTS peripheral slots. Every access is a registered transaction:
// IDLE -> ISSUE -> (RAMWAIT | WAIT) -> DONE, with a one-cycle o_Ack pulse.
// Slots can stretch the access with i_Slot_Ready; a slot that never answers
// is aborted after TIMEOUT_CYCLES wait cycles. Faults are recorded in a
// sticky status register at STATUS_ADDR.
//
// Optional build macro: MMIO_FAULT_ADDR_EN adds a read-only fault-address
// register at STATUS_ADDR-1 holding the address of the first fault since ERR
// was last cleared. Without it that address is unmapped.
//
// Ports:
//   i_CLK, i_RESET_n        clock, asynchronous active-low reset
//   i_Req, i_Write_EN       CPU request / direction (sampled in IDLE only)
//   i_Address, i_Data       CPU word address / write data
//   o_Data, o_Ack, o_Busy   read data (valid with o_Ack), completion, stall
//   o_RAM_Addr/Data         latched RAM address and shared write data
//   o_RAM_Write_EN          one-cycle RAM write strobe
//   i_RAM_Data              RAM read data, one cycle latency
//   o_Slot_Strobe           one-hot one-cycle slot access strobe
//   o_Slot_Write_EN         direction qualifier for o_Slot_Strobe
//   o_Slot_Addr             word offset within the slot
//   i_Slot_Data             flattened slot read data, slot k at [16k+15:16k]
//   i_Slot_Ready            per-slot completion
// ---------------------------------------------------------------------------
module mmio_interconnect
    import mmio_pkg::*;
#(
    parameter int          RAM_AW         = 14,
    parameter logic [15:0] PERIPH_BASE    = 16'h4000,
    parameter int          N_SLOTS        = 4,
    parameter int          SLOT_AW        = 2,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [15:0] STATUS_ADDR    = 16'h7FFF
) (
    input  logic                 i_CLK,
    input  logic                 i_RESET_n,
    input  logic                 i_Req,
    input  logic                 i_Write_EN,
    input  logic [15:0]          i_Address,
    input  logic [15:0]          i_Data,
    output logic [15:0]          o_Data,
    output logic                 o_Ack,
    output logic                 o_Busy,
    output logic [RAM_AW-1:0]    o_RAM_Addr,
    output logic [15:0]          o_RAM_Data,
    output logic                 o_RAM_Write_EN,
    input  logic [15:0]          i_RAM_Data,
    output logic [N_SLOTS-1:0]   o_Slot_Strobe,
    output logic                 o_Slot_Write_EN,
    output logic [SLOT_AW-1:0]   o_Slot_Addr,
    input  logic [16*N_SLOTS-1:0] i_Slot_Data,
    input  logic [N_SLOTS-1:0]   i_Slot_Ready
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    // Decoder outputs for the address currently on the CPU port.
    logic               dec_ram;
    logic [N_SLOTS-1:0] dec_slot;
    logic               dec_status;
    logic               dec_fault;
    logic               dec_unmapped;

    // Captured transaction.
    state_t             state_reg;
    logic               write_reg;
    logic               tgt_ram_reg;
    logic [N_SLOTS-1:0] slot_sel_reg;
    logic               tgt_status_reg;
    logic               tgt_fault_reg;
    logic               tgt_unmapped_reg;
    logic [3:0]         slot_idx_reg;
    logic [15:0]        wait_cnt_reg;
    logic [15:0]        status_reg;

    // Selected-slot view of the slot buses.
    logic [15:0]        slot_words [N_SLOTS];
    logic [15:0]        sel_data;
    logic               ready_sel;
    logic [15:0]        fault_addr_value;

    mmio_decode #(
        .RAM_AW      (RAM_AW),
        .PERIPH_BASE (PERIPH_BASE),
        .N_SLOTS     (N_SLOTS),
        .SLOT_AW     (SLOT_AW),
        .STATUS_ADDR (STATUS_ADDR)
    ) u_decode (
        .addr          (i_Address),
        .is_ram        (dec_ram),
        .is_slot       (dec_slot),
        .is_status     (dec_status),
        .is_fault_addr (dec_fault),
        .is_unmapped   (dec_unmapped)
    );

    generate
        for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot_word
            assign slot_words[gi] = i_Slot_Data[16*gi +: 16];
        end
    endgenerate

    // One-hot AND-OR mux: only the captured slot's data and ready matter,
    // so ready from any other slot is ignored by construction.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (slot_sel_reg[k]) begin
                sel_data = sel_data | slot_words[k];
            end
        end
    end

    assign ready_sel = |(i_Slot_Ready & slot_sel_reg);

`ifdef MMIO_FAULT_ADDR_EN
    logic [15:0] addr_reg;
    logic [15:0] fault_addr_reg;
    assign fault_addr_value = fault_addr_reg;
`else
    assign fault_addr_value = 16'h0000;
`endif

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state_reg        <= ST_IDLE;
            write_reg        <= 1'b0;
            tgt_ram_reg      <= 1'b0;
            slot_sel_reg     <= '0;
            tgt_status_reg   <= 1'b0;
            tgt_fault_reg    <= 1'b0;
            tgt_unmapped_reg <= 1'b0;
            slot_idx_reg     <= '0;
            wait_cnt_reg     <= '0;
            status_reg       <= '0;
            o_Data           <= '0;
            o_Ack            <= 1'b0;
            o_Busy           <= 1'b0;
            o_RAM_Addr       <= '0;
            o_RAM_Data       <= '0;
            o_RAM_Write_EN   <= 1'b0;
            o_Slot_Strobe    <= '0;
            o_Slot_Write_EN  <= 1'b0;
            o_Slot_Addr      <= '0;
`ifdef MMIO_FAULT_ADDR_EN
            addr_reg         <= '0;
            fault_addr_reg   <= '0;
`endif
        end else begin
            // Single-cycle pulses fall back to zero unless re-asserted below.
            o_Ack           <= 1'b0;
            o_RAM_Write_EN  <= 1'b0;
            o_Slot_Strobe   <= '0;
            o_Slot_Write_EN <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (i_Req) begin
                        o_Busy           <= 1'b1;
                        write_reg        <= i_Write_EN;
                        tgt_ram_reg      <= dec_ram;
                        slot_sel_reg     <= dec_slot;
                        tgt_status_reg   <= dec_status;
                        tgt_fault_reg    <= dec_fault;
                        tgt_unmapped_reg <= dec_unmapped;
                        slot_idx_reg     <= slot_index(i_Address, PERIPH_BASE, SLOT_AW);
                        o_RAM_Addr       <= i_Address[RAM_AW-1:0];
                        o_RAM_Data       <= i_Data;
                        o_Slot_Addr      <= i_Address[SLOT_AW-1:0];
                        // Strobes are registered here so they are high
                        // during the ISSUE cycle.
                        o_RAM_Write_EN   <= dec_ram && i_Write_EN;
                        o_Slot_Strobe    <= dec_slot;
                        o_Slot_Write_EN  <= (|dec_slot) && i_Write_EN;
`ifdef MMIO_FAULT_ADDR_EN
                        addr_reg         <= i_Address;
`endif
                        state_reg        <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (tgt_ram_reg) begin
                        state_reg <= ST_RAMWAIT;
                    end else if (|slot_sel_reg) begin
                        if (ready_sel) begin
                            o_Data    <= sel_data;
                            o_Ack     <= 1'b1;
                            o_Busy    <= 1'b0;
                            state_reg <= ST_DONE;
                        end else begin
                            wait_cnt_reg <= '0;
                            state_reg    <= ST_WAIT;
                        end
                    end else begin
                        // Internal registers and unmapped holes finish
                        // without touching any external bus.
                        o_Ack     <= 1'b1;
                        o_Busy    <= 1'b0;
                        state_reg <= ST_DONE;
                        if (tgt_status_reg) begin
                            o_Data <= status_reg;
                            if (write_reg) begin
                                if (o_RAM_Data[STAT_ERR_BIT]) begin
                                    status_reg[STAT_ERR_BIT] <= 1'b0;
                                end
                                if (o_RAM_Data[STAT_TIMEOUT_BIT]) begin
                                    status_reg[STAT_TIMEOUT_BIT] <= 1'b0;
                                end
                            end
                        end else if (tgt_fault_reg) begin
                            o_Data <= fault_addr_value;
                        end else begin
                            o_Data <= '0;
                        end
                        // An unmapped fault has no slot, so the recorded
                        // slot index keeps pointing at the last slot fault.
                        if (tgt_unmapped_reg) begin
                            status_reg[STAT_ERR_BIT] <= 1'b1;
`ifdef MMIO_FAULT_ADDR_EN
                            if (!status_reg[STAT_ERR_BIT]) begin
                                fault_addr_reg <= addr_reg;
                            end
`endif
                        end
                    end
                end

                ST_RAMWAIT: begin
                    o_Data    <= i_RAM_Data;
                    o_Ack     <= 1'b1;
                    o_Busy    <= 1'b0;
                    state_reg <= ST_DONE;
                end

                ST_WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg + 16'd1;
                    // Ready is tested first so it wins over a timeout that
                    // expires in the same cycle.
                    if (ready_sel) begin
                        o_Data    <= sel_data;
                        o_Ack     <= 1'b1;
                        o_Busy    <= 1'b0;
                        state_reg <= ST_DONE;
                    end else if (wait_cnt_reg + 16'd1 == TIMEOUT_LIMIT) begin
                        o_Data                               <= TIMEOUT_DATA;
                        o_Ack                                <= 1'b1;
                        o_Busy                               <= 1'b0;
                        status_reg[STAT_ERR_BIT]             <= 1'b1;
                        status_reg[STAT_TIMEOUT_BIT]         <= 1'b1;
                        status_reg[STAT_SLOT_MSB:STAT_SLOT_LSB] <= slot_idx_reg;
`ifdef MMIO_FAULT_ADDR_EN
                        if (!status_reg[STAT_ERR_BIT]) begin
                            fault_addr_reg <= addr_reg;
                        end
`endif
                        state_reg <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // i_Req is deliberately not looked at here.
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_interconnect.sv
// ---------------------------------------------------------------------------
// tb_mmio_interconnect
// Self-checking bench for mmio_interconnect: directed scenarios followed by
// randomized transactions, all checked against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_mmio_interconnect;

    localparam int          RAM_AW      = 14;
    localparam logic [15:0] PERIPH_BASE = 16'h4000;
    localparam int          N_SLOTS     = 4;
    localparam int          SLOT_AW     = 2;
    localparam int          TIMEOUT     = 255;
    localparam logic [15:0] STATUS_ADDR = 16'h7FFF;
    localparam int          SPAN        = 1 << SLOT_AW;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   req;
    logic                   we;
    logic [15:0]            addr;
    logic [15:0]            wdata;
    logic [15:0]            o_data;
    logic                   o_ack;
    logic                   o_busy;
    logic [RAM_AW-1:0]      ram_addr;
    logic [15:0]            ram_wdata;
    logic                   ram_we;
    logic [15:0]            ram_rdata;
    logic [N_SLOTS-1:0]     slot_strobe;
    logic                   slot_we;
    logic [SLOT_AW-1:0]     slot_addr;
    logic [16*N_SLOTS-1:0]  slot_data;
    logic [N_SLOTS-1:0]     slot_ready;

    always #5 clk = ~clk;

    mmio_interconnect #(
        .RAM_AW         (RAM_AW),
        .PERIPH_BASE    (PERIPH_BASE),
        .N_SLOTS        (N_SLOTS),
        .SLOT_AW        (SLOT_AW),
        .TIMEOUT_CYCLES (TIMEOUT),
        .STATUS_ADDR    (STATUS_ADDR)
    ) dut (
        .i_CLK           (clk),
        .i_RESET_n       (rst_n),
        .i_Req           (req),
        .i_Write_EN      (we),
        .i_Address       (addr),
        .i_Data          (wdata),
        .o_Data          (o_data),
        .o_Ack           (o_ack),
        .o_Busy          (o_busy),
        .o_RAM_Addr      (ram_addr),
        .o_RAM_Data      (ram_wdata),
        .o_RAM_Write_EN  (ram_we),
        .i_RAM_Data      (ram_rdata),
        .o_Slot_Strobe   (slot_strobe),
        .o_Slot_Write_EN (slot_we),
        .o_Slot_Addr     (slot_addr),
        .i_Slot_Data     (slot_data),
        .i_Slot_Ready    (slot_ready)
    );

    // Synchronous RAM attached to the fabric: one cycle read latency.
    logic [15:0] env_ram [0:(1<<RAM_AW)-1];
    always @(posedge clk) begin
        if (ram_we) env_ram[ram_addr] <= ram_wdata;
        ram_rdata <= env_ram[ram_addr];
    end

    // Reference model state.
    logic [15:0] exp_mem [int];
    logic [15:0] ram_q [$];
    bit          m_err;
    bit          m_to;
    logic [3:0]  m_idx;
    logic [15:0] m_fault;

    int n_vectors     = 0;
    int n_miscompares = 0;
    int n_txn         = 0;
    bit abort_run     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_status();
        return {8'h00, m_idx, 2'b00, m_to, m_err};
    endfunction

    // 0 = RAM, 1 = slot k, 2 = status, 3 = fault-address register, 4 = unmapped
    function automatic int classify(input logic [15:0] a, output int k);
        int ai;
        int cls;
        ai  = int'(a);
        k   = 0;
        cls = 4;
        if (ai < (1 << RAM_AW)) cls = 0;
        else if (a == STATUS_ADDR) cls = 2;
`ifdef MMIO_FAULT_ADDR_EN
        else if (a == STATUS_ADDR - 16'd1) cls = 3;
`endif
        else begin
            for (int s = 0; s < N_SLOTS; s++) begin
                if (ai >= int'(PERIPH_BASE) + s*SPAN && ai < int'(PERIPH_BASE) + (s+1)*SPAN) begin
                    cls = 1;
                    k   = s;
                end
            end
        end
        return cls;
    endfunction

    // rdy_dly: cycles after the strobe cycle before the target slot raises
    // ready (0 = ready in the strobe cycle, negative = never).
    task automatic run_txn(input bit wr, input logic [15:0] a, input logic [15:0] d,
                           input int rdy_dly, input logic [63:0] sdata);
        int          cls, k, exp_lat, lat;
        logic [15:0] exp_data, got_data;
        logic [3:0]  exp_strobe;
        bit          chk_data, busy_ok, acked;
        int          strobe_extra, we_extra;

        cls        = classify(a, k);
        exp_strobe = (cls == 1) ? (4'b0001 << k) : 4'b0000;
        chk_data   = !wr;
        exp_data   = 16'h0000;
        exp_lat    = 2;
        case (cls)
            0: begin
                exp_lat = 3;
                if (!wr) exp_data = exp_mem[int'(a)];
                else begin
                    exp_mem[int'(a)] = d;
                    ram_q.push_back(a);
                end
            end
            1: begin
                if (rdy_dly >= 0 && rdy_dly <= TIMEOUT) begin
                    exp_lat  = 2 + rdy_dly;
                    exp_data = sdata[16*k +: 16];
                end else begin
                    exp_lat  = 2 + TIMEOUT;
                    exp_data = 16'hDEAD;
                    chk_data = 1;
                    if (!m_err) m_fault = a;
                    m_err = 1;
                    m_to  = 1;
                    m_idx = 4'(k);
                end
            end
            2: begin
                exp_data = model_status();
                if (wr) begin
                    if (d[0]) m_err = 0;
                    if (d[1]) m_to  = 0;
                end
            end
            3: exp_data = m_fault;
            default: begin
                if (!m_err) m_fault = a;
                m_err = 1;
            end
        endcase

        // Cycle 0: fabric idle, present the request.
        @(negedge clk);
        check("idle_before_req", {o_ack, o_busy}, 2'b00);
        req        = 1'b1;
        we         = wr;
        addr       = a;
        wdata      = d;
        slot_data  = sdata;
        slot_ready = 4'($urandom);

        busy_ok = 1; strobe_extra = 0; we_extra = 0; acked = 0; lat = 0; got_data = '0;
        for (int n = 1; n <= TIMEOUT + 20 && !acked; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("slot_strobe", slot_strobe, exp_strobe);
                check("ram_we", ram_we, (cls == 0) && wr);
                check("slot_we", slot_we, (cls == 1) && wr);
                if (cls == 1) check("slot_addr", slot_addr, a[SLOT_AW-1:0]);
            end else begin
                if (slot_strobe != 0) strobe_extra++;
                if (ram_we) we_extra++;
            end
            if (o_ack) begin
                acked    = 1;
                lat      = n;
                got_data = o_data;
                if (o_busy) busy_ok = 0;
            end else if (!o_busy) begin
                busy_ok = 0;
            end
            // Noise on every input the fabric must ignore while busy.
            req        = 1'($urandom);
            we         = 1'($urandom);
            addr       = 16'($urandom);
            wdata      = 16'($urandom);
            slot_ready = 4'($urandom) & ~exp_strobe;
            if (cls == 1 && rdy_dly >= 0 && n >= 1 + rdy_dly) slot_ready = slot_ready | exp_strobe;
        end
        check("ack_seen", acked, 1'b1);
        if (!acked) begin
            abort_run = 1;
        end else begin
            check("latency", lat, exp_lat);
            check("busy_profile", busy_ok, 1'b1);
            check("extra_strobes", strobe_extra, 0);
            check("extra_ram_we", we_extra, 0);
            if (chk_data) check("rdata", got_data, exp_data);
        end
        n_txn++;
        $display("txn %0d %s addr=%h wdata=%h latency=%0d rdata=%h", n_txn, wr ? "WR" : "RD", a, d, lat, got_data);
    endtask

    task automatic reset_in_wait();
        @(negedge clk);
        check("idle_before_req", {o_ack, o_busy}, 2'b00);
        req = 1'b1; we = 1'b0; addr = 16'h400C; slot_ready = '0;
        @(negedge clk);
        req = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_in_wait", o_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {o_ack, o_busy, slot_strobe, slot_we, ram_we, o_data}, '0);
        m_err = 0; m_to = 0; m_idx = '0; m_fault = '0;
        @(negedge clk);
        check("no_ack_in_reset", o_ack, 1'b0);
        rst_n = 1'b1;
        n_txn++;
        $display("txn %0d RD addr=400c aborted by reset", n_txn);
    endtask

    initial begin
        int          k, kind, dly;
        bit          wr;
        logic [15:0] a;

        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        slot_data = '0; slot_ready = '0;
        m_err = 0; m_to = 0; m_idx = '0; m_fault = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {o_data, o_ack, o_busy, ram_addr, ram_wdata, ram_we,
                                slot_strobe, slot_we, slot_addr}, '0);
        rst_n = 1'b1;

        // RAM write then read back.
        run_txn(1'b1, 16'h0010, 16'h1234, 0, 64'h0);
        run_txn(1'b0, 16'h0010, 16'h0000, 0, 64'h0);
        // Zero-wait slot 1, offset 1.
        run_txn(1'b0, 16'h4005, 16'h0000, 0, {$urandom, $urandom});
        // Slot 2 ready five cycles after the strobe.
        run_txn(1'b0, 16'h4008, 16'h0000, 5, 64'h0000_BEEF_0000_0000);
        // Ready exactly on the timeout cycle wins; one later times out.
        run_txn(1'b0, 16'h4004, 16'h0000, TIMEOUT, {$urandom, $urandom});
        run_txn(1'b0, 16'h4004, 16'h0000, TIMEOUT + 1, {$urandom, $urandom});
        run_txn(1'b1, STATUS_ADDR, 16'h0003, 0, 64'h0);
        // Slot 3 never answers.
        run_txn(1'b0, 16'h400C, 16'h0000, -1, {$urandom, $urandom});
        run_txn(1'b0, STATUS_ADDR, 16'h0000, 0, 64'h0);
        run_txn(1'b1, STATUS_ADDR, 16'h0003, 0, 64'h0);
        run_txn(1'b0, STATUS_ADDR, 16'h0000, 0, 64'h0);
        // Unmapped access and the fault-address register.
        run_txn(1'b0, 16'h5000, 16'h0000, 0, 64'h0);
        run_txn(1'b0, 16'h7FFE, 16'h0000, 0, 64'h0);
        run_txn(1'b0, STATUS_ADDR, 16'h0000, 0, 64'h0);
        // Reset while a slot is stalling, then a normal transaction.
        reset_in_wait();
        run_txn(1'b0, STATUS_ADDR, 16'h0000, 0, 64'h0);
        run_txn(1'b0, 16'h0010, 16'h0000, 0, 64'h0);
        run_txn(1'b0, 16'h4001, 16'h0000, 2, {$urandom, $urandom});

        for (int t = 0; t < 250 && !abort_run; t++) begin
            kind = $urandom_range(0, 9);
            wr   = 1'($urandom);
            dly  = 0;
            if (kind <= 2) begin
                if (!wr && ram_q.size() > 0) a = ram_q[$urandom_range(0, ram_q.size() - 1)];
                else begin
                    wr = 1'b1;
                    a  = 16'($urandom_range(0, (1 << RAM_AW) - 1));
                end
            end else if (kind <= 6) begin
                a   = PERIPH_BASE + 16'($urandom_range(0, N_SLOTS*SPAN - 1));
                dly = ($urandom_range(0, 29) == 0) ? -1 : $urandom_range(0, 10);
            end else if (kind == 7) begin
                a = STATUS_ADDR;
            end else if (kind == 8) begin
                a = STATUS_ADDR - 16'd1;
            end else begin
                a = $urandom_range(0, 1) ? 16'($urandom_range(16'h4010, 16'h7FFD))
                                         : 16'($urandom_range(16'h8000, 16'hFFFF));
            end
            run_txn(wr, a, 16'($urandom), dly, {$urandom, $urandom});
        end

        @(negedge clk);
        req = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/mmio_interconnect.md
Name: mmio_interconnect

Overview:
- Parametrised memory-mapped bus fabric between the Hack CPU data port and a RAM plus N peripheral slots.
- Replaces fixed single-cycle address decode with registered request/acknowledge transactions, per-slot wait states, a bus timeout and a sticky error status register.
- Sits between the CPU core and all data-side memories and peripherals (LEDs, UART, future blocks).

Parameters:
- RAM_AW, 14, RAM word-address width; RAM occupies 0 to 2^RAM_AW-1.
- PERIPH_BASE, 16'h4000, first peripheral address; must be aligned to N_SLOTS*2^SLOT_AW.
- N_SLOTS, 4, number of peripheral slots (1-16).
- SLOT_AW, 2, word-address bits per slot; each slot spans 2^SLOT_AW words; must be at least 1.
- TIMEOUT_CYCLES, 255, WAIT cycles before a transaction is aborted (1-65535).
- STATUS_ADDR, 16'h7FFF, address of the internal bus status register.

Ports:
- i_CLK, in, 1, system clock.
- i_RESET_n, in, 1, asynchronous active-low reset.
- i_Req, in, 1, CPU request; sampled only in IDLE.
- i_Write_EN, in, 1, 1 = write, 0 = read; qualified by i_Req.
- i_Address, in, 16, CPU word address.
- i_Data, in, 16, CPU write data.
- o_Data, out, 16, read data; valid when o_Ack = 1, held until the next o_Ack.
- o_Ack, out, 1, one-cycle transaction-complete pulse.
- o_Busy, out, 1, high from request capture until o_Ack (CPU stall).
- o_RAM_Addr, out, RAM_AW, latched RAM address.
- o_RAM_Data, out, 16, latched write data (shared by all slots).
- o_RAM_Write_EN, out, 1, one-cycle RAM write strobe.
- i_RAM_Data, in, 16, RAM read data; fixed one-cycle latency.
- o_Slot_Strobe, out, N_SLOTS, one-hot one-cycle access strobe.
- o_Slot_Write_EN, out, 1, direction qualifier for o_Slot_Strobe.
- o_Slot_Addr, out, SLOT_AW, word offset within the slot.
- i_Slot_Data, in, 16*N_SLOTS, flattened read data; slot k occupies bits [16k+15:16k].
- i_Slot_Ready, in, N_SLOTS, slot completion; may be high in the strobe cycle.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; status register 0.
- Address decode: RAM if address < 2^RAM_AW. Slot k if PERIPH_BASE + k*2^SLOT_AW <= address < PERIPH_BASE + (k+1)*2^SLOT_AW. STATUS_ADDR if equal. Everything else is unmapped.
- IDLE: on i_Req, latch address, data, direction and decode result; raise o_Busy; go to ISSUE.
- ISSUE, exactly one cycle:
  - RAM target: assert o_RAM_Write_EN for writes only; go to RAMWAIT.
  - Slot k: assert o_Slot_Strobe[k]. If i_Slot_Ready[k] is high this cycle, capture i_Slot_Data[k] and go to DONE; otherwise go to WAIT.
  - Status or unmapped target: go to DONE directly.
- RAMWAIT: capture i_RAM_Data; go to DONE.
- WAIT:
  - Counter increments each cycle.
  - i_Slot_Ready[k] high: capture data, go to DONE.
  - Counter reaches TIMEOUT_CYCLES with no ready: set status bits 0 and 1, data = 16'hDEAD, go to DONE.
  - Ready and timeout in the same cycle: ready wins.
- DONE: o_Ack = 1 for one cycle; o_Busy drops on the same edge; return to IDLE.
- Minimum latency is request to o_Ack in 2 cycles (zero-wait slot, status, unmapped); RAM takes 3 cycles.
- Back-to-back: i_Req is not sampled in the DONE cycle, so the next capture happens in IDLE.
- Unmapped access: read data 0; status bit 0 (ERR) set; write discarded; no strobe issued.
- Status register:
  - bit0 ERR, sticky.
  - bit1 TIMEOUT, sticky.
  - bits[7:4] slot index of the last fault.
  - A write clears each of bits 0 and 1 where the written data bit is 1.
- Reset mid-transaction aborts immediately: no o_Ack, strobes low.
- Signals ignored in these cases:
  - i_Slot_Ready outside ISSUE/WAIT, or for a non-selected slot.
  - i_Req while o_Busy is high.

Optional Feature:
MMIO_FAULT_ADDR_EN:
- Defined:
  - A fault-address register is readable at STATUS_ADDR-1.
  - It latches the full 16-bit address of the first fault after ERR was last cleared; later faults do not overwrite it while ERR = 1.
- Undefined:
  - STATUS_ADDR-1 decodes as unmapped.
  - No register exists.

Decomposition:
- Package mmio_pkg holds:
  - FSM state encoding (IDLE, ISSUE, RAMWAIT, WAIT, DONE).
  - Status bit indices.
  - Constant 16'hDEAD (TIMEOUT_DATA).
  - A function computing the slot index from an address.
- Sub-module mmio_decode: combinational address decoder producing RAM / slot one-hot / status / unmapped. It is instantiated once and feeds the capture registers.

Test Plan:
- Write 16'h1234 to 0x0010, then read 0x0010: o_RAM_Write_EN pulses once; read o_Ack arrives 3 cycles after i_Req with o_Data = 16'h1234.
- Read 0x4005 with slot 1 ready held high: o_Slot_Strobe = 4'b0010 and o_Slot_Addr = 1 in the same cycle; o_Ack arrives 2 cycles after i_Req.
- Slot 2 ready asserted 5 cycles after strobe with data 16'hBEEF: o_Busy stays high throughout; o_Data = 16'hBEEF at o_Ack.
- Slot 3 never ready: o_Ack arrives after TIMEOUT_CYCLES wait cycles with o_Data = 16'hDEAD; status reads 16'h0033; writing 16'h0003 then reading status gives 16'h0030.
- Read unmapped 0x5000: o_Data = 0, no strobe, ERR set. With MMIO_FAULT_ADDR_EN, reading 0x7FFE returns 16'h5000.
- Drop i_RESET_n during WAIT: outputs go to 0 asynchronously; no o_Ack; the next transaction completes normally.
